// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter
//   Shares the write port and read port 1 of the central register file
//   between two requesters (A = core datapath, B = debug/boot loader) using
//   round-robin arbitration. Only one access is in flight at a time. A
//   hardware clear sweep writes zero to every register, one per cycle.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   a_* / b_*           requester command (valid/ready) and response
//                       (rvalid pulse, rdata held until the next response)
//   clear_req           level request for a full register clear
//   clear_busy          sweep in progress
//   clear_done          one-cycle pulse after the last clear write
//   rf_addr1, rf_data1  register file read port 1 (combinational read data)
//   rf_waddr, rf_wdata,
//   rf_we               register file write port (written on negedge)
module regfile_access_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] rf_addr1,
  input  logic [DATA_W-1:0] rf_data1,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_CLEAR  = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e              state_q;
  logic                last_grant_q;  // 0 = A, 1 = B
  logic                owner_q;       // 0 = A, 1 = B
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                a_rvalid_q, b_rvalid_q;
  logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;
  logic                clear_busy_q, clear_done_q;
  logic [ADDR_W-1:0]   rf_addr1_q, rf_waddr_q;
  logic [DATA_W-1:0]   rf_wdata_q;
  logic                rf_we_q;

  // Ready is only offered in IDLE, out of reset, when no clear is pending.
  // On a tie the requester that was not granted last wins.
  logic grant_ok;
  logic a_fire, b_fire;

  assign grant_ok = (state_q == S_IDLE) && rst && !clear_req;
  assign a_ready  = grant_ok && a_valid && (!b_valid || last_grant_q);
  assign b_ready  = grant_ok && b_valid && (!a_valid || !last_grant_q);
  assign a_fire   = a_valid && a_ready;
  assign b_fire   = b_valid && b_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      clr_cnt_q    <= '0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
      rf_addr1_q   <= '0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      rf_we_q      <= 1'b0;
    end else begin
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      clear_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clear_req) begin
            // First clear write is issued in the very first CLEAR cycle.
            state_q      <= S_CLEAR;
            clear_busy_q <= 1'b1;
            clr_cnt_q    <= '0;
            rf_we_q      <= 1'b1;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
          end else if (a_fire || b_fire) begin
            rf_addr1_q   <= b_fire ? b_addr  : a_addr;
            rf_waddr_q   <= b_fire ? b_addr  : a_addr;
            rf_wdata_q   <= b_fire ? b_wdata : a_wdata;
            rf_we_q      <= b_fire ? b_write : a_write;
            owner_q      <= b_fire;
            last_grant_q <= b_fire;
            state_q      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // A write responds with the data it just stored; a read returns
          // the file output for the latched read address.
          if (owner_q) begin
            b_rvalid_q <= 1'b1;
            b_rdata_q  <= rf_we_q ? rf_wdata_q : rf_data1;
          end else begin
            a_rvalid_q <= 1'b1;
            a_rdata_q  <= rf_we_q ? rf_wdata_q : rf_data1;
          end
          rf_we_q <= 1'b0;
          state_q <= S_IDLE;
        end
        S_CLEAR: begin
          if (clr_cnt_q == LAST_IDX) begin
            rf_we_q      <= 1'b0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            clr_cnt_q  <= clr_cnt_q + 1'b1;
            rf_waddr_q <= clr_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign a_rvalid   = a_rvalid_q;
  assign b_rvalid   = b_rvalid_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;
  assign clear_busy = clear_busy_q;
  assign clear_done = clear_done_q;
  assign rf_addr1   = rf_addr1_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign rf_we      = rf_we_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Testbench for regfile_access_arbiter: drives both requesters and clear
// requests, models the register file, and compares every cycle against a
// transaction-level timing model (availability windows, response due
// cycles, clear windows).
module tb_regfile_access_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk, rst;
  logic          a_valid, a_write, a_ready, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_valid, b_write, b_ready, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          clear_req, clear_busy, clear_done;
  logic [AW-1:0] rf_addr1, rf_waddr;
  logic [DW-1:0] rf_data1, rf_wdata;
  logic          rf_we;

  regfile_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
    .rf_addr1(rf_addr1), .rf_data1(rf_data1),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: combinational read, write on negedge.
  logic [DW-1:0] rf_mem [NR];
  assign rf_data1 = rf_mem[rf_addr1];
  always @(negedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

  // Reference model state
  logic [DW-1:0] ref_mem [NR];
  int            n, avail_at, resp_due, acc_cyc, cs;
  bit            last_b, resp_b, acc_we, in_reset;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wd, resp_data, exp_rd_a, exp_rd_b;

  // Requester command state
  bit            a_pend, a_w, b_pend, b_w, clr_hold, a_auto, b_auto;
  logic [AW-1:0] a_ad, b_ad;
  logic [DW-1:0] a_wd, b_wd;

  int n_checks, n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    #1;
  endtask

  task automatic drive();
    a_valid = a_pend; a_write = a_w; a_addr = a_ad; a_wdata = a_wd;
    b_valid = b_pend; b_write = b_w; b_addr = b_ad; b_wdata = b_wd;
    clear_req = clr_hold;
  endtask

  task automatic new_a();
    a_pend = 1'b1; a_w = 1'($urandom_range(0, 1));
    a_ad = AW'($urandom_range(0, NR - 1)); a_wd = $urandom;
  endtask

  task automatic new_b();
    b_pend = 1'b1; b_w = 1'($urandom_range(0, 1));
    b_ad = AW'($urandom_range(0, NR - 1)); b_wd = $urandom;
  endtask

  task automatic model_reset();
    in_reset = 1'b1; last_b = 1'b1; cs = -1000; resp_due = -1; acc_cyc = -1;
    exp_rd_a = '0; exp_rd_b = '0;
  endtask

  // Check the current cycle against the model, then advance the model to
  // what the coming posedge commits.
  task automatic eval();
    bit idle, ea, eb, in_clr, we_exp, isb, w;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    #1;
    idle   = !in_reset && (n >= avail_at);
    ea     = idle && !clr_hold && a_pend && (!b_pend || last_b);
    eb     = idle && !clr_hold && b_pend && (!a_pend || !last_b);
    in_clr = !in_reset && (n >= cs) && (n < cs + NR);
    if (!in_reset && n == resp_due) begin
      if (resp_b) exp_rd_b = resp_data; else exp_rd_a = resp_data;
    end
    we_exp = in_clr || (!in_reset && n == acc_cyc && acc_we);

    check_eq("a_ready", 32'(a_ready), 32'(ea));
    check_eq("b_ready", 32'(b_ready), 32'(eb));
    check_eq("a_rvalid", 32'(a_rvalid), 32'(!in_reset && n == resp_due && !resp_b));
    check_eq("b_rvalid", 32'(b_rvalid), 32'(!in_reset && n == resp_due && resp_b));
    check_eq("a_rdata", a_rdata, exp_rd_a);
    check_eq("b_rdata", b_rdata, exp_rd_b);
    check_eq("clear_busy", 32'(clear_busy), 32'(in_clr));
    check_eq("clear_done", 32'(clear_done), 32'(!in_reset && n == cs + NR));
    check_eq("rf_we", 32'(rf_we), 32'(we_exp));
    if (in_reset) begin
      check_eq("rst_rf_addr1", 32'(rf_addr1), 32'd0);
      check_eq("rst_rf_waddr", 32'(rf_waddr), 32'd0);
      check_eq("rst_rf_wdata", rf_wdata, 32'd0);
    end
    if (in_clr) begin
      check_eq("clr_waddr", 32'(rf_waddr), 32'(n - cs));
      check_eq("clr_wdata", rf_wdata, 32'd0);
      ref_mem[n - cs] = '0;
    end
    if (!in_reset && n == acc_cyc) begin
      check_eq("acc_addr1", 32'(rf_addr1), 32'(acc_addr));
      if (acc_we) begin
        check_eq("acc_waddr", 32'(rf_waddr), 32'(acc_addr));
        check_eq("acc_wdata", rf_wdata, acc_wd);
      end
    end

    if (idle && clr_hold) begin
      cs = n + 1; avail_at = n + 1 + NR; clr_hold = 1'b0;
    end else if (ea || eb) begin
      isb = eb;
      w  = isb ? b_w  : a_w;
      ad = isb ? b_ad : a_ad;
      wd = isb ? b_wd : a_wd;
      acc_cyc = n + 1; avail_at = n + 2; resp_due = n + 2; resp_b = isb;
      acc_we = w; acc_addr = ad; acc_wd = wd;
      resp_data = w ? wd : ref_mem[ad];
      if (w) ref_mem[ad] = wd;
      last_b = isb;
      if (isb) b_pend = 1'b0; else a_pend = 1'b0;
    end
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) begin
      tick();
      if (a_auto && !a_pend) new_a();
      if (b_auto && !b_pend) new_b();
      drive();
      eval();
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n = 0; avail_at = 0;
    for (int i = 0; i < NR; i++) begin
      rf_mem[i]  = $urandom;
      ref_mem[i] = rf_mem[i];
    end
    model_reset();
    a_auto = 0; b_auto = 0; clr_hold = 0; b_pend = 0; b_w = 0; b_ad = '0; b_wd = '0;
    // A write of DEADBEEF to r12 held across reset.
    a_pend = 1; a_w = 1; a_ad = 5'd12; a_wd = 32'hDEADBEEF;
    rst = 1'b0;
    drive();
    run(3);
    // Release: A must be ready in the same cycle.
    tick(); rst = 1'b1; in_reset = 1'b0; avail_at = n; drive(); eval();
    run(1);
    b_pend = 1; b_w = 0; b_ad = 5'd12;
    run(5);
    check_eq("b_read_r12", b_rdata, 32'hDEADBEEF);

    // Both requesters saturate: alternating grants.
    a_auto = 1; b_auto = 1;
    run(12);
    a_auto = 0; b_auto = 0; a_pend = 0; b_pend = 0;
    run(3);

    // Clear requested while B's read is in ACCESS.
    b_pend = 1; b_w = 0; b_ad = 5'd7;
    run(1);
    clr_hold = 1;
    run(NR + 4);
    a_pend = 1; a_w = 0; a_ad = 5'd5;
    run(4);
    check_eq("a_read_r5_zero", a_rdata, 32'd0);

    // Seed r2 and r20, then abort a sweep by reset in its 10th cycle.
    a_pend = 1; a_w = 1; a_ad = 5'd2; a_wd = 32'h1111_1111;
    b_pend = 1; b_w = 1; b_ad = 5'd20; b_wd = 32'h2222_2222;
    run(6);
    clr_hold = 1;
    run(10);
    tick(); rst = 1'b0; #1;
    check_eq("abort_rf_we", 32'(rf_we), 32'd0);
    check_eq("abort_busy", 32'(clear_busy), 32'd0);
    model_reset();
    a_pend = 1; a_w = 0; a_ad = 5'd2;
    drive();
    run(2);
    tick(); rst = 1'b1; in_reset = 1'b0; avail_at = n; drive(); eval();
    run(2);
    check_eq("r2_cleared", a_rdata, 32'd0);
    b_pend = 1; b_w = 0; b_ad = 5'd20;
    run(3);
    check_eq("r20_kept", b_rdata, 32'h2222_2222);

    // Clear and an A read of r3 rising together: clear wins.
    a_pend = 1; a_w = 0; a_ad = 5'd3; clr_hold = 1;
    run(NR + 6);
    check_eq("a_read_r3_zero", a_rdata, 32'd0);

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 500; i++) begin
      if (!a_pend && $urandom_range(0, 2) == 0) new_a();
      if (!b_pend && $urandom_range(0, 2) == 0) new_b();
      if (!clr_hold && $urandom_range(0, 79) == 0) clr_hold = 1;
      run(1);
    end
    a_pend = 0; b_pend = 0; clr_hold = 0;
    run(NR + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
